// File: rtl/temporizador_int.sv
// -----------------------------------------------------------------------------
// temporizador_int
//
// A memory-mapped interval timer combined with an external interrupt
// collector. It exposes a four-word register window at BASE:
//   BASE+0 CTRL   : bit0 EN, bit1 AUTO, bits[12:8] MASK
//                   (bits 8..7+N_EXT gate the external lines, bit12 the timer)
//   BASE+1 PRESC  : prescaler reload value, so one tick = PRESC+1 cycles
//   BASE+2 RELOAD : tick count reload value, so expiry = RELOAD+1 ticks
//   BASE+3 STATUS : bits[N_EXT-1:0] external pending, bit4 timer pending;
//                   a write of 1 to a bit clears it (W1C)
// Addresses outside the window read as 0 and ignore writes.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low; clears every register
//   we           bus write strobe
//   direcciones  bus address
//   datos_in     bus write data
//   datos_out    combinational read data for the addressed register
//   ext_int      asynchronous external interrupt requests (N_EXT lines)
//   ack          one-hot acknowledge from the datapath (bit i clears pending i)
//   int_e        pending & mask; bits above the implemented lines are 0
//
// Configuration
//   TEMPORIZADOR_SYNC2_EN defined   : 2-flop synchronizer, an ext_int rise
//                                     reaches pending after 3 clock edges.
//   TEMPORIZADOR_SYNC2_EN undefined : 1-flop synchronizer, 2 clock edges.
// -----------------------------------------------------------------------------
module temporizador_int #(
  parameter logic [15:0] BASE  = 16'hFF00,
  parameter int          N_EXT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [15:0]      direcciones,
  input  logic [15:0]      datos_in,
  output logic [15:0]      datos_out,
  input  logic [N_EXT-1:0] ext_int,
  input  logic [7:0]       ack,
  output logic [7:0]       int_e
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Lines that physically exist among the four external slots.
  localparam logic [3:0]  EXT_MASK   = 4'((1 << N_EXT) - 1);
  // Only EN, AUTO and the implemented MASK bits are storable in CTRL.
  localparam logic [15:0] CTRL_WMASK = {3'b000, 1'b1, EXT_MASK, 6'b000000, 2'b11};
  localparam logic [4:0]  PEND_MASK  = {1'b1, EXT_MASK};

  state_t      state_q, state_d;

  logic [15:0] ctrl_q,   ctrl_d;
  logic [15:0] presc_q;
  logic [15:0] reload_q;
  logic [15:0] pcnt_q,   pcnt_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [4:0]  pend_q,   pend_d;
  logic [4:0]  pend_set, pend_clr;

  logic [15:0] offset;
  logic        hit;
  logic        wr_ctrl, wr_presc, wr_reload, wr_status;
  logic        expire;

  logic [N_EXT-1:0] ext_sync;
  logic [N_EXT-1:0] ext_prev;
  logic [N_EXT-1:0] ext_rise;

  // ack[7:5] have no interrupt source behind them.
  logic unused_ack;
  assign unused_ack = ^ack[7:5];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // A modular offset makes BASE-1 land on 16'hFFFF, which is outside the window.
  assign offset    = direcciones - BASE;
  assign hit       = (offset < 16'd4);
  assign wr_ctrl   = we & hit & (offset[1:0] == 2'd0);
  assign wr_presc  = we & hit & (offset[1:0] == 2'd1);
  assign wr_reload = we & hit & (offset[1:0] == 2'd2);
  assign wr_status = we & hit & (offset[1:0] == 2'd3);

  always_comb begin
    datos_out = 16'h0000;
    if (hit) begin
      case (offset[1:0])
        2'd0:    datos_out = ctrl_q;
        2'd1:    datos_out = presc_q;
        2'd2:    datos_out = reload_q;
        default: datos_out = {11'b0, pend_q};
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // External line synchronizer, stage p0 (and p1 when two flops are used)
  // ---------------------------------------------------------------------------
`ifdef TEMPORIZADOR_SYNC2_EN
  logic [N_EXT-1:0] ext_sync_p0;
  logic [N_EXT-1:0] ext_sync_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_sync_p0 <= '0;
      ext_sync_p1 <= '0;
    end else begin
      ext_sync_p0 <= ext_int;
      ext_sync_p1 <= ext_sync_p0;
    end
  end

  assign ext_sync = ext_sync_p1;
`else
  logic [N_EXT-1:0] ext_sync_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_sync_p0 <= '0;
    end else begin
      ext_sync_p0 <= ext_int;
    end
  end

  assign ext_sync = ext_sync_p0;
`endif

  // ---------------------------------------------------------------------------
  // Edge detect against the previous synchronized value
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_prev <= '0;
    end else begin
      ext_prev <= ext_sync;
    end
  end

  // Only a rising edge requests service, so a held level fires once.
  assign ext_rise = ext_sync & ~ext_prev;

  // ---------------------------------------------------------------------------
  // Timer next-state and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d = ctrl_q;
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    expire = 1'b0;

    if (state_q == RUN) begin
      if (pcnt_q == 16'd0) begin
        // Prescaler wrap: one tick of the main counter.
        pcnt_d = presc_q;
        if (cnt_q == 16'd0) begin
          expire = 1'b1;
          if (ctrl_q[1]) begin
            cnt_d = reload_q;
          end else begin
            ctrl_d[0] = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end else begin
        pcnt_d = pcnt_q - 16'd1;
      end
    end

    // A software CTRL write overrides the hardware EN clear above.
    if (wr_ctrl) begin
      ctrl_d = datos_in & CTRL_WMASK;
      if (!datos_in[0]) begin
        // Disabling freezes the counters where they stand.
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
      end else if ((state_q == IDLE) || (expire && !ctrl_q[1])) begin
        // Fresh start (either from IDLE or rescuing a one-shot expiry).
        pcnt_d = presc_q;
        cnt_d  = reload_q;
      end
    end

    state_d = ctrl_d[0] ? RUN : IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= 16'h0000;
      presc_q  <= 16'h0000;
      reload_q <= 16'h0000;
      pcnt_q   <= 16'h0000;
      cnt_q    <= 16'h0000;
    end else begin
      ctrl_q <= ctrl_d;
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      // New values are picked up only at the next reload of the counters.
      if (wr_presc) begin
        presc_q <= datos_in;
      end
      if (wr_reload) begin
        reload_q <= datos_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending register
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_set             = 5'b00000;
    pend_set[N_EXT-1:0]  = ext_rise;
    pend_set[4]          = expire;
  end

  assign pend_clr = ack[4:0] | (wr_status ? datos_in[4:0] : 5'b00000);

  // Set is applied after clear so a simultaneous event is never lost.
  assign pend_d = ((pend_q & ~pend_clr) | pend_set) & PEND_MASK;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 5'b00000;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Straight AND of registered bits keeps int_e glitch-free and zero in reset.
  assign int_e = {3'b000, pend_q & {ctrl_q[12], ctrl_q[11:8]}};

endmodule

// File: tb/tb_temporizador_int.sv
module tb_temporizador_int;

  localparam logic [15:0] B = 16'hFF00;
`ifdef TEMPORIZADOR_SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [15:0] direcciones;
  logic [15:0] datos_in;
  logic [15:0] datos_out;
  logic [3:0]  ext_int;
  logic [7:0]  ack;
  logic [7:0]  int_e;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } sb_item_t;

  sb_item_t sb[$];

  always #5 clk = ~clk;

  temporizador_int #(
    .BASE  (B),
    .N_EXT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .direcciones (direcciones),
    .datos_in    (datos_in),
    .datos_out   (datos_out),
    .ext_int     (ext_int),
    .ack         (ack),
    .int_e       (int_e)
  );

  task automatic expect_v(input string tag, input logic [15:0] v);
    sb_item_t it;
    it.tag = tag;
    it.val = v;
    sb.push_back(it);
  endtask

  task automatic chk(input logic [15:0] obs);
    sb_item_t it;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    we          = 1'b1;
    direcciones = a;
    datos_in    = d;
    @(posedge clk);
    #1;
    we          = 1'b0;
    datos_in    = 16'h0000;
  endtask

  task automatic rd_chk(input logic [15:0] a);
    direcciones = a;
    @(negedge clk);
    chk(datos_out);
  endtask

  task automatic int_chk();
    chk({8'h00, int_e});
  endtask

  initial begin
    reset       = 1'b0;
    we          = 1'b0;
    direcciones = B;
    datos_in    = 16'h0000;
    ext_int     = 4'h0;
    ack         = 8'h00;

    // Reset state
    cyc(2);
    expect_v("rst_int_e",  16'h0000);
    expect_v("rst_ctrl",   16'h0000);
    expect_v("rst_presc",  16'h0000);
    expect_v("rst_reload", 16'h0000);
    expect_v("rst_status", 16'h0000);
    int_chk();
    rd_chk(B);
    rd_chk(B + 16'd1);
    rd_chk(B + 16'd2);
    rd_chk(B + 16'd3);
    reset = 1'b1;
    cyc(1);

    // Scenario 1: one-shot, PRESC=1 RELOAD=2 -> fires 6 cycles after enable
    bus_write(B + 16'd1, 16'h0001);
    bus_write(B + 16'd2, 16'h0002);
    expect_v("s1_before", 16'h0000);
    expect_v("s1_fire",   16'h0010);
    expect_v("s1_ctrl_en_cleared", 16'h1000);
    expect_v("s1_presc",  16'h0001);
    expect_v("s1_reload", 16'h0002);
    expect_v("s1_status", 16'h0010);
    bus_write(B, 16'h1001);
    cyc(5);
    int_chk();
    cyc(1);
    int_chk();
    rd_chk(B);
    rd_chk(B + 16'd1);
    rd_chk(B + 16'd2);
    rd_chk(B + 16'd3);
    expect_v("s1_w1c",  16'h0000);
    expect_v("s1_idle", 16'h0000);
    bus_write(B + 16'd3, 16'h0010);
    int_chk();
    cyc(10);
    int_chk();

    // Scenario 2: auto-reload, PRESC=0 RELOAD=3 -> every 4 cycles, ack clears
    bus_write(B + 16'd1, 16'h0000);
    bus_write(B + 16'd2, 16'h0003);
    expect_v("s2_e3",     16'h0000);
    expect_v("s2_e4",     16'h0010);
    expect_v("s2_ack",    16'h0000);
    expect_v("s2_e7",     16'h0000);
    expect_v("s2_e8",     16'h0010);
    expect_v("s2_ack2",   16'h0000);
    bus_write(B, 16'h1003);
    cyc(3);
    int_chk();
    cyc(1);
    int_chk();
    ack = 8'h10;
    cyc(1);
    ack = 8'h00;
    int_chk();
    cyc(2);
    int_chk();
    cyc(1);
    int_chk();
    ack = 8'h10;
    cyc(1);
    ack = 8'h00;
    int_chk();
    cyc(2);

    // Scenario 4: W1C in the very cycle of expiry -> the set wins
    expect_v("s4_set_wins",  16'h0010);
    expect_v("s4_status",    16'h0010);
    bus_write(B + 16'd3, 16'h0010);
    int_chk();
    rd_chk(B + 16'd3);
    bus_write(B, 16'h1000);
    bus_write(B + 16'd3, 16'h0010);
    expect_v("s2_disabled", 16'h0000);
    expect_v("s2_frozen",   16'h0000);
    int_chk();
    cyc(8);
    int_chk();

    // PRESC=0 RELOAD=0: expiry every cycle, ack cannot beat a same-cycle set
    bus_write(B + 16'd2, 16'h0000);
    expect_v("pc0_first",    16'h0010);
    expect_v("pc0_ack_lose", 16'h0010);
    expect_v("pc0_off",      16'h0000);
    bus_write(B, 16'h1003);
    cyc(1);
    int_chk();
    ack = 8'h10;
    cyc(1);
    ack = 8'h00;
    int_chk();
    bus_write(B, 16'h1000);
    bus_write(B + 16'd3, 16'h0010);
    int_chk();

    // Scenario 3: external edge on line 2, masked in
    bus_write(B, 16'h0400);
    expect_v("s3_early",     16'h0000);
    expect_v("s3_arrive",    16'h0004);
    expect_v("s3_cleared",   16'h0000);
    expect_v("s3_level_held", 16'h0000);
    expect_v("s3_status",    16'h0000);
    ext_int = 4'b0100;
    cyc(LAT - 1);
    int_chk();
    cyc(1);
    int_chk();
    bus_write(B + 16'd3, 16'h0004);
    int_chk();
    cyc(5);
    int_chk();
    rd_chk(B + 16'd3);

    // Line 1 masked out: pending visible in STATUS only, ack clears it
    expect_v("mask_int_e",    16'h0000);
    expect_v("mask_status",   16'h0002);
    expect_v("mask_ack_clr",  16'h0000);
    ext_int = 4'b0110;
    cyc(LAT);
    int_chk();
    rd_chk(B + 16'd3);
    ack = 8'h02;
    cyc(1);
    ack = 8'h00;
    rd_chk(B + 16'd3);
    ext_int = 4'b0000;

    // Scenario 6: addresses just outside the window
    expect_v("s6_read_hi",   16'h0000);
    expect_v("s6_read_lo",   16'h0000);
    expect_v("s6_ctrl",      16'h0400);
    expect_v("s6_presc",     16'h0000);
    expect_v("s6_reload",    16'h0000);
    expect_v("s6_status",    16'h0000);
    rd_chk(B + 16'd4);
    rd_chk(B - 16'd1);
    bus_write(B + 16'd4, 16'hFFFF);
    bus_write(B - 16'd1, 16'hFFFF);
    rd_chk(B);
    rd_chk(B + 16'd1);
    rd_chk(B + 16'd2);
    rd_chk(B + 16'd3);

    // Scenario 5: all five pending, then reset pulsed between edges
    expect_v("s5_all_pending", 16'h001F);
    expect_v("s5_status",      16'h001F);
    ext_int = 4'hF;
    bus_write(B, 16'h1F03);
    cyc(LAT);
    int_chk();
    rd_chk(B + 16'd3);
    @(posedge clk);
    #3;
    expect_v("s5_async_int_e", 16'h0000);
    expect_v("s5_ctrl",        16'h0000);
    reset = 1'b0;
    #1;
    int_chk();
    rd_chk(B);
    ext_int = 4'h0;
    cyc(2);
    reset = 1'b1;
    cyc(3);
    expect_v("s5_after_int_e",  16'h0000);
    expect_v("s5_after_status", 16'h0000);
    int_chk();
    rd_chk(B + 16'd3);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
